// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline controller and the stages it steers: stall requests,
// commit-point status in, pause/flush/redirect out.
interface pipeline_ctrl_if #(
  parameter int unsigned PAUSE_WIDTH = 8
);
  logic [4:0]             pause_req;
  logic                   mem_valid;
  logic [5:0]             mem_is_exception;
  logic [31:0]            mem_pc;
  logic                   mem_is_ertn;
  logic                   mem_is_idle;
  logic                   interrupt_pending;
  logic [31:0]            csr_eentry;
  logic [31:0]            csr_era;
  logic                   ex_branch_mispredict;
  logic [31:0]            ex_branch_target;
  logic [PAUSE_WIDTH-1:0] pause;
  logic                   exception_flush;
  logic                   branch_flush;
  logic                   new_pc_valid;
  logic [31:0]            new_pc;
  logic                   is_interrupt;
  logic                   idle_state;

  modport master (
    input  pause_req, mem_valid, mem_is_exception, mem_pc, mem_is_ertn, mem_is_idle,
           interrupt_pending, csr_eentry, csr_era, ex_branch_mispredict, ex_branch_target,
    output pause, exception_flush, branch_flush, new_pc_valid, new_pc, is_interrupt,
           idle_state
  );

  modport slave (
    output pause_req, mem_valid, mem_is_exception, mem_pc, mem_is_ertn, mem_is_idle,
           interrupt_pending, csr_eentry, csr_era, ex_branch_mispredict, ex_branch_target,
    input  pause, exception_flush, branch_flush, new_pc_valid, new_pc, is_interrupt,
           idle_state
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stall requests into the pause vector and sequences
// commit-point redirects (interrupt, exception, ertn, idle) and branch mispredict flushes.
module pipeline_ctrl #(
  parameter logic [31:0] PC_RESET    = 32'h1c000000,
  parameter int unsigned PAUSE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_ctrl_if.master       bus
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StFlush = 2'd1;
  localparam logic [1:0] StIdle  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        exception_flush_q, exception_flush_d;
  logic        branch_flush_q, branch_flush_d;
  logic        new_pc_valid_q, new_pc_valid_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        is_interrupt_q, is_interrupt_d;

  logic [4:0]             req;
  logic [PAUSE_WIDTH-1:0] pause_c;
  logic                   commit_ok;
  logic                   mem_exc;
  logic                   commit_event;

  // pause_req packs {if, id, dispatch, ex, mem} from MSB to LSB.
  assign req = bus.pause_req;

  always_comb begin
    pause_c    = '0;
    pause_c[0] = |req;
    pause_c[1] = |req;
    pause_c[2] = |req[3:0];
    pause_c[3] = |req[2:0];
    pause_c[4] = |req[1:0];
    pause_c[5] = req[0];
    if (state_q == StIdle) pause_c[1:0] = 2'b11;
    if (exception_flush_q) pause_c = '0;
  end

  assign commit_ok    = (state_q == StRun) && bus.mem_valid && !req[0];
  assign mem_exc      = |bus.mem_is_exception;
  assign commit_event = commit_ok &&
                        (bus.interrupt_pending || mem_exc || bus.mem_is_ertn || bus.mem_is_idle);

  always_comb begin
    state_d           = state_q;
    exception_flush_d = 1'b0;
    branch_flush_d    = 1'b0;
    new_pc_valid_d    = 1'b0;
    new_pc_d          = new_pc_q;
    is_interrupt_d    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (commit_event) begin
          exception_flush_d = 1'b1;
          new_pc_valid_d    = 1'b1;
          state_d           = StFlush;
          if (bus.interrupt_pending) begin
            new_pc_d       = bus.csr_eentry;
            is_interrupt_d = 1'b1;
          end else if (mem_exc) begin
            new_pc_d = bus.csr_eentry;
          end else if (bus.mem_is_ertn) begin
            new_pc_d = bus.csr_era;
          end else begin
            new_pc_d = bus.mem_pc + 32'd4;
            state_d  = StIdle;
          end
        end else if (bus.ex_branch_mispredict && !req[1]) begin
          // Younger than any commit event, so only taken when none fires.
          branch_flush_d = 1'b1;
          new_pc_valid_d = 1'b1;
          new_pc_d       = bus.ex_branch_target;
        end
      end
      StFlush: state_d = StRun;
      StIdle: begin
        if (bus.interrupt_pending) begin
          exception_flush_d = 1'b1;
          new_pc_valid_d    = 1'b1;
          new_pc_d          = bus.csr_eentry;
          is_interrupt_d    = 1'b1;
          state_d           = StFlush;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= StRun;
      exception_flush_q <= 1'b0;
      branch_flush_q    <= 1'b0;
      new_pc_valid_q    <= 1'b0;
      new_pc_q          <= PC_RESET;
      is_interrupt_q    <= 1'b0;
    end else begin
      state_q           <= state_d;
      exception_flush_q <= exception_flush_d;
      branch_flush_q    <= branch_flush_d;
      new_pc_valid_q    <= new_pc_valid_d;
      new_pc_q          <= new_pc_d;
      is_interrupt_q    <= is_interrupt_d;
    end
  end

  assign bus.pause           = pause_c;
  assign bus.exception_flush = exception_flush_q;
  assign bus.branch_flush    = branch_flush_q;
  assign bus.new_pc_valid    = new_pc_valid_q;
  assign bus.new_pc          = new_pc_q;
  assign bus.is_interrupt    = is_interrupt_q;
  assign bus.idle_state      = (state_q == StIdle);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: pause map, commit redirects, idle/interrupt, branch
// priority and reset recovery, against hand-computed values.
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipeline_ctrl_if #(.PAUSE_WIDTH(8)) bus ();

  pipeline_ctrl #(
    .PC_RESET   (32'h1c000000),
    .PAUSE_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pause_req            = '0;
    bus.mem_valid            = 1'b0;
    bus.mem_is_exception     = '0;
    bus.mem_is_ertn          = 1'b0;
    bus.mem_is_idle          = 1'b0;
    bus.interrupt_pending    = 1'b0;
    bus.ex_branch_mispredict = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".eflush"}, {31'd0, bus.exception_flush}, 32'd0);
    check({tag, ".bflush"}, {31'd0, bus.branch_flush}, 32'd0);
    check({tag, ".npc_v"}, {31'd0, bus.new_pc_valid}, 32'd0);
    check({tag, ".npc"}, bus.new_pc, 32'h1c000000);
    check({tag, ".is_int"}, {31'd0, bus.is_interrupt}, 32'd0);
    check({tag, ".idle"}, {31'd0, bus.idle_state}, 32'd0);
    check({tag, ".pause"}, {24'd0, bus.pause}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    bus.mem_pc           = 32'h0;
    bus.csr_eentry       = 32'h1c008000;
    bus.csr_era          = 32'h1c0000a4;
    bus.ex_branch_target = 32'h1c000200;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // Pause map
    bus.pause_req = 5'b00010; #1;
    check("pause_ex", {24'd0, bus.pause}, 32'h1f);
    bus.pause_req = 5'b10000; #1;
    check("pause_if", {24'd0, bus.pause}, 32'h03);
    bus.pause_req = 5'b00001; #1;
    check("pause_mem", {24'd0, bus.pause}, 32'h3f);
    bus.pause_req = 5'b00100; #1;
    check("pause_disp", {24'd0, bus.pause}, 32'h0f);
    bus.pause_req = 5'b01000; #1;
    check("pause_id", {24'd0, bus.pause}, 32'h07);

    // Commit blocked by mem stall
    bus.pause_req = 5'b00001;
    bus.mem_valid = 1'b1;
    bus.mem_is_exception = 6'b000100;
    step();
    check("stalled_commit", {31'd0, bus.exception_flush}, 32'd0);
    clear_inputs();

    // Exception
    bus.mem_valid = 1'b1;
    bus.mem_is_exception = 6'b000100;
    step();
    clear_inputs();
    bus.pause_req = 5'b00010;
    bus.mem_valid = 1'b1;
    bus.mem_is_ertn = 1'b1;
    #1;
    check("exc.eflush", {31'd0, bus.exception_flush}, 32'd1);
    check("exc.npc_v", {31'd0, bus.new_pc_valid}, 32'd1);
    check("exc.npc", bus.new_pc, 32'h1c008000);
    check("exc.pause", {24'd0, bus.pause}, 32'd0);
    check("exc.is_int", {31'd0, bus.is_interrupt}, 32'd0);
    step();
    check("exc.end", {31'd0, bus.exception_flush}, 32'd0);
    check("exc.flush_ignores", {31'd0, bus.new_pc_valid}, 32'd0);
    check("exc.hold", bus.new_pc, 32'h1c008000);
    clear_inputs();
    step();

    // ertn
    bus.mem_valid = 1'b1;
    bus.mem_is_ertn = 1'b1;
    step();
    clear_inputs();
    check("ertn.eflush", {31'd0, bus.exception_flush}, 32'd1);
    check("ertn.npc", bus.new_pc, 32'h1c0000a4);
    check("ertn.is_int", {31'd0, bus.is_interrupt}, 32'd0);
    step();
    check("ertn.end", {31'd0, bus.exception_flush}, 32'd0);

    // idle, then wake on interrupt
    bus.mem_valid = 1'b1;
    bus.mem_is_idle = 1'b1;
    bus.mem_pc = 32'h1c000100;
    step();
    clear_inputs();
    check("idle.eflush", {31'd0, bus.exception_flush}, 32'd1);
    check("idle.npc", bus.new_pc, 32'h1c000104);
    step();
    for (int i = 0; i < 10; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_is_exception = 6'b000001;
      bus.ex_branch_mispredict = 1'b1;
      #1;
      check("idle.state", {31'd0, bus.idle_state}, 32'd1);
      check("idle.pause", {24'd0, bus.pause}, 32'h03);
      step();
      check("idle.no_flush", {30'd0, bus.exception_flush, bus.branch_flush}, 32'd0);
    end
    clear_inputs();
    bus.interrupt_pending = 1'b1;
    step();
    clear_inputs();
    check("wake.eflush", {31'd0, bus.exception_flush}, 32'd1);
    check("wake.npc_v", {31'd0, bus.new_pc_valid}, 32'd1);
    check("wake.npc", bus.new_pc, 32'h1c008000);
    check("wake.is_int", {31'd0, bus.is_interrupt}, 32'd1);
    check("wake.idle", {31'd0, bus.idle_state}, 32'd0);
    step();
    check("wake.end", {31'd0, bus.is_interrupt}, 32'd0);

    // Branch with simultaneous exception: exception wins
    bus.mem_valid = 1'b1;
    bus.mem_is_exception = 6'b100000;
    bus.ex_branch_mispredict = 1'b1;
    step();
    clear_inputs();
    check("both.eflush", {31'd0, bus.exception_flush}, 32'd1);
    check("both.bflush", {31'd0, bus.branch_flush}, 32'd0);
    check("both.npc", bus.new_pc, 32'h1c008000);
    step();

    // Branch stalled in ex
    bus.ex_branch_mispredict = 1'b1;
    bus.pause_req = 5'b00010;
    step();
    check("br_stall", {31'd0, bus.branch_flush}, 32'd0);
    clear_inputs();

    // Branch alone
    bus.ex_branch_mispredict = 1'b1;
    step();
    clear_inputs();
    check("br.bflush", {31'd0, bus.branch_flush}, 32'd1);
    check("br.eflush", {31'd0, bus.exception_flush}, 32'd0);
    check("br.npc_v", {31'd0, bus.new_pc_valid}, 32'd1);
    check("br.npc", bus.new_pc, 32'h1c000200);
    step();
    check("br.end", {31'd0, bus.branch_flush}, 32'd0);

    // Interrupt beats exception at commit
    bus.mem_valid = 1'b1;
    bus.interrupt_pending = 1'b1;
    bus.mem_is_exception = 6'b000010;
    bus.csr_eentry = 32'h1c00c000;
    step();
    clear_inputs();
    check("int.npc", bus.new_pc, 32'h1c00c000);
    check("int.is_int", {31'd0, bus.is_interrupt}, 32'd1);
    step();

    // idle at top of address space wraps; reset mid-IDLE
    bus.mem_valid = 1'b1;
    bus.mem_is_idle = 1'b1;
    bus.mem_pc = 32'hfffffffc;
    step();
    clear_inputs();
    check("wrap.npc", bus.new_pc, 32'h00000000);
    step();
    check("wrap.idle", {31'd0, bus.idle_state}, 32'd1);
    rst = 1'b1;
    bus.interrupt_pending = 1'b1;
    step();
    rst = 1'b0;
    clear_inputs();
    check_reset_state("rst_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
